// File: rtl/seg_display_scan_if.sv
// Bus bundle between the calculator core and the seven-segment scanner:
// load/value request, busy status and the multiplexed display outputs.
interface seg_display_scan_if;
    logic [7:0] value;
    logic       load;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (
        output value,
        output load,
        input  busy,
        input  seg,
        input  an
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output seg,
        output an
    );
endinterface

// File: rtl/seg_display_scan.sv
// 4-digit multiplexed seven-segment driver with a sequential double-dabble
// binary-to-BCD converter. Optional macro DISP_SIGNED_EN: two's complement input with minus sign.
module seg_display_scan #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_display_scan_if.slave bus
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    logic [1:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic [3:0]    disp_h_q, disp_h_d;
    logic [3:0]    disp_t_q, disp_t_d;
    logic [3:0]    disp_o_q, disp_o_d;
    logic          disp_sign_q, disp_sign_d;
    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [11:0]   adj;
    logic [6:0]    glyph;
    logic          terminal;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Conversion FSM; display registers only change in DONE so no partial BCD is shown
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        disp_h_d    = disp_h_q;
        disp_t_d    = disp_t_q;
        disp_o_d    = disp_o_q;
        disp_sign_d = disp_sign_q;
        adj         = bcd_q;

        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
`ifdef DISP_SIGNED_EN
                    sign_d  = bus.value[7];
                    shift_d = bus.value[7] ? (~bus.value + 8'd1) : bus.value;
`else
                    sign_d  = 1'b0;
                    shift_d = bus.value;
`endif
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = {adj[10:0], shift_q, 1'b0};
                cnt_d            = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_h_d    = bcd_q[11:8];
                disp_t_d    = bcd_q[7:4];
                disp_o_d    = bcd_q[3:0];
                disp_sign_d = sign_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan path; glyph is decoded from next-state display regs so a commit shows on its own edge
    always_comb begin
        terminal = (ref_q == CW'(REFRESH_DIV - 1));
        ref_d    = terminal ? '0 : ref_q + CW'(1);
        idx_d    = terminal ? idx_q + 2'd1 : idx_q;
        an_d     = ~(4'b0001 << idx_q);
        glyph    = GLYPH_BLANK;

        case (idx_q)
            2'd0: glyph = glyph_of(disp_o_d);
            2'd1: begin
                if (disp_h_d != 4'd0 || disp_t_d != 4'd0) begin
                    glyph = glyph_of(disp_t_d);
                end
            end
            2'd2: begin
                if (disp_h_d != 4'd0) begin
                    glyph = glyph_of(disp_h_d);
                end
            end
            default: begin
                if (disp_sign_d) begin
                    glyph = GLYPH_MINUS;
                end
            end
        endcase

        seg_d = SEG_ACTIVE_LOW ? ~glyph : glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            disp_h_q    <= '0;
            disp_t_q    <= '0;
            disp_o_q    <= '0;
            disp_sign_q <= 1'b0;
            ref_q       <= '0;
            idx_q       <= '0;
            an_q        <= 4'b1110;
            seg_q       <= SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            disp_h_q    <= disp_h_d;
            disp_t_q    <= disp_t_d;
            disp_o_q    <= disp_o_d;
            disp_sign_q <= disp_sign_d;
            ref_q       <= ref_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized bench for seg_display_scan: a cycle-level behavioural model of the
// display contents and scan position is compared with the DUT every cycle.
module tb_seg_display_scan;

    localparam int unsigned DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_display_scan_if bus();

    seg_display_scan #(
        .REFRESH_DIV   (DIV),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: conversion countdown, pending and displayed value, edges since reset
    int m_left  = 0;
    int m_pend  = 0;
    int m_shown = 0;
    int m_edges = 0;
    bit m_psign = 1'b0;
    bit m_sign  = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [7:0] v);
`ifdef DISP_SIGNED_EN
        return v[7] ? 256 - int'(v) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic bit sign_of(input logic [7:0] v);
`ifdef DISP_SIGNED_EN
        return v[7];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  -2: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int cur_digit();
        return (m_edges == 0) ? 0 : ((m_edges - 1) / DIV) % 4;
    endfunction

    function automatic logic [6:0] exp_seg();
        int d;
        int sym;
        d = cur_digit();
        case (d)
            0:       sym = m_shown % 10;
            1:       sym = (m_shown >= 10) ? (m_shown / 10) % 10 : -1;
            2:       sym = (m_shown >= 100) ? m_shown / 100 : -1;
            default: sym = m_sign ? -2 : -1;
        endcase
        return ~glyph(sym);
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << cur_digit());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_pend  = 0;
            m_shown = 0;
            m_edges = 0;
            m_psign = 1'b0;
            m_sign  = 1'b0;
        end else begin
            m_edges++;
            if (m_left == 0) begin
                if (bus.load) begin
                    m_left  = 9;
                    m_pend  = mag_of(bus.value);
                    m_psign = sign_of(bus.value);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_shown = m_pend;
                    m_sign  = m_psign;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(bus.busy), int'(m_left != 0));
        check("an",   int'(bus.an),   int'(exp_an()));
        check("seg",  int'(bus.seg),  int'(exp_seg()));
    end

    task automatic load_pulse(input logic [7:0] v);
        @(negedge clk);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // Counts busy cycles from the negedge after the accepting edge; optional ignored reload at cycle 3
    task automatic count_busy(input bit reload, output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 40) begin
            cnt++;
            bus.load  = reload && (cnt == 3);
            bus.value = 8'd99;
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] tgt, input logic [6:0] exp, input string nm);
        int k;
        k = 0;
        while (bus.an !== tgt && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (bus.an !== tgt) begin
            check({nm, "_timeout"}, int'(bus.an), int'(tgt));
        end else begin
            check(nm, int'(bus.seg), int'(exp));
            check({nm, "_model"}, int'(exp_seg()), int'(exp));
        end
    endtask

    initial begin
        int cnt;
        int k;
        logic [3:0] prev_an;

        bus.value = '0;
        bus.load  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_an",   int'(bus.an),   4'b1110);
        check("reset_seg",  int'(bus.seg),  7'h40);
        check("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;

`ifndef DISP_SIGNED_EN
        load_pulse(8'd255);
        count_busy(1'b0, cnt);
        check("busy_len_255", cnt, 9);
        wait_an(4'b1011, 7'h24, "d2_255");
        wait_an(4'b1101, 7'h12, "d1_255");
        wait_an(4'b1110, 7'h12, "d0_255");
        wait_an(4'b0111, 7'h7F, "d3_255");

        load_pulse(8'd7);
        count_busy(1'b0, cnt);
        wait_an(4'b1011, 7'h7F, "d2_7");
        wait_an(4'b1101, 7'h7F, "d1_7");
        wait_an(4'b1110, 7'h78, "d0_7");

        load_pulse(8'd40);
        count_busy(1'b0, cnt);
        wait_an(4'b1011, 7'h7F, "d2_40");
        wait_an(4'b1101, 7'h19, "d1_40");
        wait_an(4'b1110, 7'h40, "d0_40");

        load_pulse(8'd123);
        count_busy(1'b1, cnt);
        check("busy_len_ignored", cnt, 9);
        wait_an(4'b1011, 7'h79, "d2_123");
        wait_an(4'b1101, 7'h24, "d1_123");
        wait_an(4'b1110, 7'h30, "d0_123");
`else
        load_pulse(8'h80);
        count_busy(1'b0, cnt);
        check("busy_len_80", cnt, 9);
        wait_an(4'b0111, 7'h3F, "d3_m128");
        wait_an(4'b1011, 7'h79, "d2_m128");
        wait_an(4'b1101, 7'h24, "d1_m128");
        wait_an(4'b1110, 7'h00, "d0_m128");

        load_pulse(8'hFF);
        count_busy(1'b0, cnt);
        wait_an(4'b0111, 7'h3F, "d3_m1");
        wait_an(4'b1011, 7'h7F, "d2_m1");
        wait_an(4'b1101, 7'h7F, "d1_m1");
        wait_an(4'b1110, 7'h79, "d0_m1");
`endif

        // Digit hold time: measure one full run of an between two changes
        prev_an = bus.an;
        k = 0;
        while (bus.an === prev_an && k < 40) begin
            @(negedge clk);
            k++;
        end
        prev_an = bus.an;
        k = 0;
        while (bus.an === prev_an && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("digit_hold", k, DIV);

        // Reset mid-conversion
        load_pulse(8'd200);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_an",   int'(bus.an),   4'b1110);
        check("midreset_seg",  int'(bus.seg),  7'h40);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.value = 8'($urandom);
            bus.load  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Output-side counterpart of the keypad scanner. The keypad path scans columns to read digits; this block scans digit anodes to drive a 4-digit multiplexed seven-segment display. It accepts an 8-bit result from the calculator core on a load strobe and converts it to BCD with a sequential double-dabble engine. It then refreshes one digit at a time from a free-running divider.

## Interface
- REFRESH_DIV, 100000, clk cycles each digit stays selected; legal range ≥2
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode); 0 = active-high
- clk  input  1  system clock; the single clock domain
- rst_n  input  1  asynchronous, active-low reset
- value  input  8  binary value to display; sampled only on an accepted load
- load  input  1  one-cycle request to convert and display value
- busy  output  1  high while a conversion is in progress
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an  output  4  digit enables, active-low one-hot; an[0] = ones digit … an[3] = leftmost

## Operation
- Conversion FSM states and transitions:
  - IDLE: load=1 captures the magnitude of value into an 8-bit shift register and clears a 12-bit BCD register (hundreds, tens, ones). Next state is SHIFT with count 0.
  - SHIFT: one iteration per cycle. Add 3 to each BCD nibble ≥5, then shift {BCD, shift} left by 1 and increment count. After the 8th iteration, go to DONE.
  - DONE: copy the BCD nibbles and the sign flag into the display registers in the same cycle. Return to IDLE.
- busy = 1 in SHIFT and DONE.
- load is ignored when not in IDLE; it is not queued.
- Display registers update only in DONE, so the scan never shows partial BCD.
- Scan path, independent of the FSM:
  - refresh counter runs 0..REFRESH_DIV-1.
  - At the terminal count, the counter wraps to 0 and the digit index advances 0→1→2→3→0.
- Digit content:
  - Digit 0: ones, always shown.
  - Digit 1: tens, blanked when hundreds = 0 and tens = 0.
  - Digit 2: hundreds, blanked when it is 0.
  - Digit 3: blank, except the sign case under DISP_SIGNED_EN.
- Active-high glyphs:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus=40, blank=00.
  - seg = ~glyph when SEG_ACTIVE_LOW=1.
- Any nibble value above 9 is unreachable; decode it as blank.

## Timing
- Reset values, applied asynchronously:
  - FSM in IDLE, busy=0, shift, BCD and count registers cleared.
  - Display registers = 0, sign=0.
  - Refresh counter 0, digit index 0.
  - an=4'b1110; seg = glyph "0" (7'h40 when active-low, 7'h3F when active-high).
- Load latency:
  - load high at edge E → busy=1 after E.
  - Iterations run on edges E+1..E+8.
  - DONE commit occurs on edge E+9; busy=0 after E+9, and the new digits are visible from that edge.
  - busy is high for exactly 9 cycles.
- Back-to-back loads: load may be accepted again in the first cycle after busy falls.
- load asserted on the DONE cycle is ignored.
- Reset mid-conversion aborts the conversion; the display returns to "0".
- an and seg are registered outputs. They change together, one cycle after the digit index advances, so there is no cross-digit glitch.
- Each digit is held for exactly REFRESH_DIV cycles; a full frame is 4×REFRESH_DIV cycles.

## Configuration
- DISP_SIGNED_EN defined:
  - value is two's complement.
  - On load, sign = value[7] and magnitude = −value when negative. 8'h80 gives magnitude 128.
  - Digit 3 shows minus when sign=1, otherwise blank.
- DISP_SIGNED_EN undefined:
  - value is unsigned 0..255, sign is forced to 0, and digit 3 is always blank.

## Test plan
- Reset: rst_n low mid-scan → immediately an=1110 and seg=7'h40 (SEG_ACTIVE_LOW=1); busy=0.
- Unsigned load 8'd255 → busy high for exactly 9 cycles; then digits 2/1/0 show 7'h6D^7F-inverted patterns for 2, 5 and 5 (active-high 5B, 6D, 6D); digit 3 blank.
- Load 8'd7, then 8'd40 → first "  7" with digits 2 and 1 blank; then " 40" with tens shown and hundreds blank.
- load pulsed again 3 cycles into a conversion → ignored; the first value is displayed, and busy still falls at E+9.
- REFRESH_DIV=4 → an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles, with seg changing in the same cycle as an.
- DISP_SIGNED_EN defined with SEG_ACTIVE_LOW=0:
  - 8'h80 → digit 3 = 40, digits 2..0 = 06, 5B, 7F (reads "-128").
  - 8'hFF → digit 3 = 40, digits 2 and 1 = 00, digit 0 = 06 (reads "-  1").
  - Reset asserted at E+4 → display "0", busy=0.
